// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage iterative divider: FSM states,
// handshake levels and the ALU op codes that select it.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle; returns
// {remainder, quotient} and holds it until the request is dropped.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic               busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               signed_q, signed_d;
  logic               sgn1_q, sgn1_d;
  logic               sgn2_q, sgn2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               dz_q, dz_d;

  logic               ge;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH:0]   step;
  logic [WIDTH-1:0]   abs1, abs2, quot, rem;

  // Top working bit never sets; folding it into ge keeps the full register observed.
  always_comb begin
    ge   = work_q[2*WIDTH] | (work_q[2*WIDTH-1:WIDTH-1] >= {1'b0, dvsr_q});
    diff = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr_q};
    if (ge) step = {diff, work_q[WIDTH-2:0], 1'b1};
    else    step = {work_q[2*WIDTH-1:0], 1'b0};
  end

  always_comb begin
    abs1 = (signed_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
    abs2 = (signed_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;
    quot = (signed_q && (sgn1_q ^ sgn2_q)) ? ('0 - work_q[WIDTH-1:0]) : work_q[WIDTH-1:0];
    rem  = (signed_q && sgn1_q) ? ('0 - work_q[2*WIDTH-1:WIDTH]) : work_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvsr_d   = dvsr_q;
    signed_d = signed_q;
    sgn1_d   = sgn1_q;
    sgn2_d   = sgn2_q;
    result_d = result_q;
    ready_d  = ready_q;
    dz_d     = dz_q;

    unique case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          signed_d = signed_i;
          sgn1_d   = opdata1_i[WIDTH-1];
          sgn2_d   = opdata2_i[WIDTH-1];
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            dvsr_d  = abs2;
            cnt_d   = '0;
            work_d  = {{(WIDTH+1){1'b0}}, abs1};
            state_d = DivOn;
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          dz_d     = 1'b1;
          ready_d  = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
          dz_d     = 1'b0;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d  = DivEnd;
          result_d = {rem, quot};
          ready_d  = DivResultReady;
          dz_d     = 1'b0;
        end else begin
          work_d = step;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
          dz_d     = 1'b0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      signed_q <= 1'b0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      signed_q <= signed_d;
      sgn1_q   <= sgn1_d;
      sgn2_q   <= sgn2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      dz_q     <= dz_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign div_zero_o = dz_q;
  assign busy_o     = (state_q != DivFree);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a 32-bit instance driven from a vector
// table plus hand-written annul/reset sequences, and an 8-bit instance.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start = 1'b0, sgn = 1'b0, annul = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] res;
  logic        rdy, dz, busy;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic        rdy8, dz8, busy8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn),
    .opdata1_i(a), .opdata2_i(b), .annul_i(annul),
    .result_o(res), .ready_o(rdy), .div_zero_o(dz), .busy_o(busy)
  );

  div_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .signed_i(sgn8),
    .opdata1_i(a8), .opdata2_i(b8), .annul_i(1'b0),
    .result_o(res8), .ready_o(rdy8), .div_zero_o(dz8), .busy_o(busy8)
  );

  typedef struct {
    logic        sg;
    logic [31:0] x, y, q, r;
    logic        z;
    int          lat;
  } vec_t;

  typedef struct {
    logic       sg;
    logic [7:0] x, y, q, r;
    int         lat;
  } vec8_t;

  vec_t  vt[12];
  vec8_t v8[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Operands are scrambled right after acceptance to confirm they are not re-sampled.
  task automatic run32(input logic sg, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic z, output int lat);
    @(negedge clk);
    sgn = sg; a = x; b = y; start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin a = ~x; b = y + 32'd3; sgn = ~sg; end
    end while (!rdy && lat < 100);
    q = res[31:0]; r = res[63:32]; z = dz;
  endtask

  task automatic run8(input logic sg, input logic [7:0] x, input logic [7:0] y,
                      output logic [7:0] q, output logic [7:0] r, output int lat);
    @(negedge clk);
    sgn8 = sg; a8 = x; b8 = y; start8 = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin a8 = ~x; b8 = ~y; end
    end while (!rdy8 && lat < 40);
    q = res8[7:0]; r = res8[15:8];
  endtask

  initial begin
    logic [31:0] q, r;
    logic        z;
    int          lat;
    logic [7:0]  q8, r8;
    bit          seen;

    vt[0]  = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        1'b0, 34};
    vt[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
    vt[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
    vt[3]  = '{1'b0, 32'd5,         32'd0,        32'd0,        32'd0,        1'b1, 2};
    vt[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34};
    vt[5]  = '{1'b0, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 34};
    vt[6]  = '{1'b0, 32'd9,         32'd3,        32'd3,        32'd0,        1'b0, 34};
    vt[7]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 34};
    vt[8]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34};
    vt[9]  = '{1'b0, 32'd0,         32'd5,        32'd0,        32'd0,        1'b0, 34};
    vt[10] = '{1'b1, 32'hFFFFFFFF,  32'd0,        32'd0,        32'd0,        1'b1, 2};
    vt[11] = '{1'b0, 32'h12345678,  32'd1000,     32'h0004A90B, 32'h00000380, 1'b0, 34};

    v8[0] = '{1'b0, 8'd200, 8'd15, 8'd13, 8'd5,  10};
    v8[1] = '{1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 10};
    v8[2] = '{1'b1, 8'h80,  8'd3,  8'hD6, 8'hFE, 10};
    v8[3] = '{1'b0, 8'd255, 8'd16, 8'd15, 8'd15, 10};
    v8[4] = '{1'b0, 8'd7,   8'd9,  8'd0,  8'd7,  10};

    #1;
    chk("reset.result", res, 64'd0);
    chk("reset.ready", 64'(rdy), 64'd0);
    chk("reset.dz", 64'(dz), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run32(vt[i].sg, vt[i].x, vt[i].y, q, r, z, lat);
      chk($sformatf("v%0d.latency", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d.quot", i), 64'(q), 64'(vt[i].q));
      chk($sformatf("v%0d.rem", i), 64'(r), 64'(vt[i].r));
      chk($sformatf("v%0d.dz", i), 64'(z), 64'(vt[i].z));
      @(posedge clk); #1;
      chk($sformatf("v%0d.hold", i), {31'd0, rdy, q, r}, {31'd0, 1'b1, vt[i].q, vt[i].r});
      @(negedge clk) start = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d.release", i), {res[61:0], rdy, busy}, 64'd0);
      chk($sformatf("v%0d.release_dz", i), 64'(dz), 64'd0);
    end

    // annul at step 10, then a normal request
    @(negedge clk);
    sgn = 1'b0; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk) annul = 1'b1;
    @(posedge clk); #1;
    chk("annul10.busy", 64'(busy), 64'd0);
    chk("annul10.ready", 64'(rdy), 64'd0);
    @(negedge clk) begin annul = 1'b0; start = 1'b0; end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (rdy) seen = 1'b1; end
    chk("annul10.no_ready", 64'(seen), 64'd0);
    run32(1'b0, 32'd9, 32'd3, q, r, z, lat);
    chk("after_annul.result", {q, r}, {32'd3, 32'd0});
    @(negedge clk) start = 1'b0;
    @(posedge clk);

    // annul on the completion edge wins
    @(negedge clk);
    sgn = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (32) @(posedge clk);
    @(negedge clk) annul = 1'b1;
    @(posedge clk); #1;
    chk("annul_done.ready", 64'(rdy), 64'd0);
    chk("annul_done.busy", 64'(busy), 64'd0);
    chk("annul_done.result", res, 64'd0);
    @(negedge clk) begin annul = 1'b0; start = 1'b0; end

    // annul in FREE blocks accept
    @(negedge clk) begin annul = 1'b1; start = 1'b1; a = 32'd9; b = 32'd3; end
    repeat (3) @(posedge clk);
    #1 chk("annul_free.busy", 64'(busy), 64'd0);
    @(negedge clk) begin annul = 1'b0; start = 1'b0; end

    // annul while holding a result in END
    run32(1'b0, 32'd9, 32'd3, q, r, z, lat);
    @(negedge clk) annul = 1'b1;
    @(posedge clk); #1;
    chk("annul_end.out", {res[62:0], rdy}, 64'd0);
    chk("annul_end.busy", 64'(busy), 64'd0);
    @(negedge clk) begin annul = 1'b0; start = 1'b0; end

    // asynchronous reset mid-ON
    @(negedge clk);
    sgn = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("rst_on.busy", 64'(busy), 64'd0);
    chk("rst_on.ready", 64'(rdy), 64'd0);
    start = 1'b0;
    @(negedge clk) rst = 1'b1;

    // asynchronous reset while a result is held
    run32(1'b0, 32'd100, 32'd7, q, r, z, lat);
    #2 rst = 1'b0;
    #1 chk("rst_end.result", res, 64'd0);
    chk("rst_end.flags", {61'd0, rdy, dz, busy}, 64'd0);
    start = 1'b0;
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run8(v8[i].sg, v8[i].x, v8[i].y, q8, r8, lat);
      chk($sformatf("w8_%0d.latency", i), 64'(lat), 64'(v8[i].lat));
      chk($sformatf("w8_%0d.result", i), {48'd0, r8, q8}, {48'd0, v8[i].r, v8[i].q});
      chk($sformatf("w8_%0d.dz", i), 64'(dz8), 64'd0);
      @(negedge clk) start8 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("w8_%0d.release", i), {46'd0, res8, rdy8, busy8}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised, multi-cycle iterative divider for the EX stage of the five-stage core. It accepts a signed or unsigned division request from EX, computes one quotient bit per cycle using radix-2 restoring shift-subtract, and returns a packed {remainder, quotient} result. The result sits where the HI/LO write data comes from. While the divider is busy, EX holds its request and raises `stallreq` to `ctrl`, the same way the MADD/MSUB path stalls today.

## Interface
- `WIDTH`, default 32: operand width; legal values are ≥ 2.
- `CNT_W`, localparam = $clog2(WIDTH+1): width of the step counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `start_i`  in  1  division request; EX holds it high until `ready_o` is seen.
- `signed_i`  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- `opdata1_i`  in  WIDTH  dividend; sampled at accept.
- `opdata2_i`  in  WIDTH  divisor; sampled at accept.
- `annul_i`  in  1  cancel the operation (pipeline flush); highest priority after reset.
- `result_o`  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; registered.
- `ready_o`  out  1  result valid; registered.
- `div_zero_o`  out  1  divisor was zero; valid while `ready_o`=1; registered.
- `busy_o`  out  1  state != FREE; decoded from the state register.

## Operation
- **States:** FREE, BY_ZERO, ON, END. Encodings live in `defines.v`.
- **FREE:**
  - On `start_i`=1 and `annul_i`=0, sample the operands.
  - Divisor == 0 → go to BY_ZERO.
  - Otherwise latch |dividend| and |divisor| (absolute values only when `signed_i`=1), latch both operand sign bits, clear `cnt`, clear the 2*WIDTH+1 working register and load |dividend| into its low half, then go to ON.
- **ON, one step per cycle:**
  - diff = working[2W-1:W-1] - {0,|divisor|}.
  - If diff ≥ 0: working = {diff[W-1:0], working[W-2:0], 1}.
  - Else: working = {working[2W-1:0], 0}.
  - `cnt` increments on each step.
- **ON exit:**
  - When `cnt`==WIDTH, go to END and register `result_o`.
  - Quotient is negated when `signed_i` and the two operand signs differ.
  - Remainder is negated when `signed_i` and the dividend is negative.
  - All arithmetic is modulo 2^WIDTH.
- **Overflow case:** signed MIN / -1 returns quotient = MIN (wrapped) and remainder = 0. No flag is raised.
- **BY_ZERO:** go to END with `result_o`=0 and `div_zero_o`=1.
- **END:**
  - `ready_o`=1 and the result is held.
  - When `start_i`=0, go to FREE and clear `ready_o`, `div_zero_o` and `result_o` to 0.
- **Annul:** `annul_i`=1 in ON, BY_ZERO or END → FREE next edge; outputs are cleared and no result is produced. In FREE, `annul_i`=1 blocks accept.
- **Reset:** `rst`=0 → state FREE; `cnt`, working register, `result_o`, `ready_o`, `div_zero_o` all go to 0 immediately, including mid-operation. `busy_o`=0 follows from the state.

## Timing
- **Normal latency:** the accept edge is E0; steps occur on E1..EW; END is entered on E(W+1). `ready_o` is high from the cycle after E(W+1), i.e. WIDTH+2 cycles after `start_i` is first seen high in FREE.
- **Divide by zero:** `ready_o` is high after E1 (2 cycles).
- **Result hold:** `ready_o` stays high for as long as `start_i` is held. It drops one edge after `start_i` falls.
- **Back-to-back:** a new request is accepted no earlier than the edge after END → FREE. Minimum turnaround is one FREE cycle.
- **EX stall:** EX stalls on `start_i` && !`ready_o`.
- **Mid-operation changes:** operand or `signed_i` changes after accept are ignored.
- **Simultaneous events:** `annul_i` together with completion → annul wins and `ready_o` stays 0.

## Structure
- `defines.v` gets:
  - state encodings `DivFree`/`DivByZero`/`DivOn`/`DivEnd`;
  - `DivStart`/`DivStop` and `DivResultReady`/`DivResultNotReady`;
  - new ALU op codes for DIV/DIVU.
- Single module, no sub-module. The one-step subtract is a local combinational block.
- Top-level wiring:
  - EX drives `start_i`, `signed_i` and the operands.
  - `ctrl` flush drives `annul_i`.
  - `result_o` feeds EX `hi_o`/`lo_o` with remainder→HI and quotient→LO.

## Test plan
- Unsigned 100 / 7, WIDTH=32 → quotient 14, remainder 2, `div_zero_o`=0; `ready_o` rises exactly 34 cycles after the start is accepted.
- Signed -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 → quotient 0xFFFFFFFD, remainder 1.
- 5 / 0 → `div_zero_o`=1, `result_o`=0, `ready_o` after 2 cycles. Deassert `start_i` → `ready_o`=0 and `busy_o`=0 one edge later.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Annul at step 10 → `busy_o`=0 next cycle and no `ready_o`. Then 9 / 3 → quotient 3, remainder 0.
- Drop `rst` low mid-ON → all outputs 0 asynchronously. WIDTH=8 instance, unsigned 200 / 15 → quotient 13, remainder 5, ready after 10 cycles.
